// File: rtl/riscv_pkg.sv
// Shared RISC-V core types and constants.
// Register address type, register count and scoreboard depth default.
package riscv_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned SB_MAX_OUTSTANDING = 4;

  typedef logic [4:0] reg_addr_t;

  // One-hot decode of a register address onto bits 31..1.
  // Address 0 decodes to all zeros since x0 is never tracked.
  function automatic logic [NUM_REGS-1:1] reg_dec(
    input reg_addr_t a
  );
    logic [NUM_REGS-1:1] d;
    d = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      d[i] = (a == reg_addr_t'(i));
    end
    return d;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks pending writes of long-latency ops and
// stalls ID on RAW, WAW or capacity hazards.
//
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   issue_*              ID-stage instruction requesting issue
//   flush_i              kills the ID-stage instruction this cycle
//   wb_valid_i, wb_rd_i  long-latency writeback
//   stall_o              hold ID (combinational)
//   pending_o            per-register pending-write bits (bit 0 is 0)
//   outstanding_o        in-flight long op count, busy_o = count != 0
//   err_o                sticky protocol error
module reg_scoreboard
  import riscv_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = SB_MAX_OUTSTANDING
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                issue_valid_i,
  input  reg_addr_t           issue_rs1_i,
  input  reg_addr_t           issue_rs2_i,
  input  logic                issue_uses_rs1_i,
  input  logic                issue_uses_rs2_i,
  input  reg_addr_t           issue_rd_i,
  input  logic                issue_long_i,
  input  logic                flush_i,
  input  logic                wb_valid_i,
  input  reg_addr_t           wb_rd_i,
  output logic                stall_o,
  output logic [NUM_REGS-1:0] pending_o,
  output logic [3:0]          outstanding_o,
  output logic                busy_o,
  output logic                err_o
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  logic [NUM_REGS-1:1] r_pend;
  logic [3:0]          r_cnt;
  logic                r_err;

  logic [NUM_REGS-1:1] w_wb_oh;
  logic [NUM_REGS-1:1] w_rd_oh;
  logic [NUM_REGS-1:1] w_eff31;
  logic [NUM_REGS-1:0] w_eff;
  logic [NUM_REGS-1:1] w_set;
  logic [NUM_REGS-1:1] w_clr;
  logic [NUM_REGS-1:1] w_pend_nxt;
  logic                w_raw;
  logic                w_waw;
  logic                w_cap;
  logic                w_req;
  logic                w_acc;
  logic                w_inc;
  logic                w_dec;
  logic                w_wb_bad;
  logic                w_underflow;
  logic [3:0]          w_cnt_nxt;

  assign w_wb_oh = reg_dec(wb_rd_i);
  assign w_rd_oh = reg_dec(issue_rd_i);

  // Same-cycle writeback releases its register for hazard checks.
  assign w_eff31 = wb_valid_i ? (r_pend & ~w_wb_oh) : r_pend;
  assign w_eff   = {w_eff31, 1'b0};

  assign w_raw = (issue_uses_rs1_i & w_eff[issue_rs1_i])
               | (issue_uses_rs2_i & w_eff[issue_rs2_i]);
  assign w_waw = (issue_rd_i != '0) & w_eff[issue_rd_i];
  assign w_cap = issue_long_i & (r_cnt == MAX_CNT) & ~wb_valid_i;

  assign w_req   = issue_valid_i & ~flush_i;
  assign stall_o = w_req & (w_raw | w_waw | w_cap);
  assign w_acc   = w_req & ~stall_o;

  assign w_inc = w_acc & issue_long_i;
  assign w_dec = wb_valid_i;

  // Set is applied after clear so a same-register collision keeps it set.
  assign w_set      = w_inc ? w_rd_oh : '0;
  assign w_clr      = wb_valid_i ? w_wb_oh : '0;
  assign w_pend_nxt = (r_pend & ~w_clr) | w_set;

  // Writeback to a register that was never marked pending.
  assign w_wb_bad = wb_valid_i & (wb_rd_i != '0)
                  & ~(|(r_pend & w_wb_oh));

  // Writeback with nothing in flight and no issue to offset it.
  assign w_underflow = w_dec & ~w_inc & (r_cnt == '0);

  always_comb begin
    w_cnt_nxt = r_cnt;
    unique case (1'b1)
      (w_inc & ~w_dec): w_cnt_nxt = r_cnt + 4'd1;
      (w_dec & ~w_inc & (r_cnt != '0)): w_cnt_nxt = r_cnt - 4'd1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pend <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      r_cnt  <= w_cnt_nxt;
      if (w_wb_bad | w_underflow) begin
        r_err <= 1'b1;
      end
    end
  end

  assign pending_o     = {r_pend, 1'b0};
  assign outstanding_o = r_cnt;
  assign busy_o        = (r_cnt != '0);
  assign err_o         = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard.
// Inputs change 1ns after the rising edge; outputs are checked mid-cycle.
module tb_reg_scoreboard;
  import riscv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        iv;
  reg_addr_t   rs1;
  reg_addr_t   rs2;
  logic        u1;
  logic        u2;
  reg_addr_t   rd;
  logic        lng;
  logic        fl;
  logic        wbv;
  reg_addr_t   wbrd;
  logic        stall;
  logic [31:0] pend;
  logic [3:0]  outs;
  logic        busy;
  logic        err;

  int total = 0;
  int bad = 0;

  reg_scoreboard #(.MAX_OUTSTANDING(4)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .issue_valid_i    (iv),
    .issue_rs1_i      (rs1),
    .issue_rs2_i      (rs2),
    .issue_uses_rs1_i (u1),
    .issue_uses_rs2_i (u2),
    .issue_rd_i       (rd),
    .issue_long_i     (lng),
    .flush_i          (fl),
    .wb_valid_i       (wbv),
    .wb_rd_i          (wbrd),
    .stall_o          (stall),
    .pending_o        (pend),
    .outstanding_o    (outs),
    .busy_o           (busy),
    .err_o            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr();
    iv = 0; rs1 = 0; rs2 = 0; u1 = 0; u2 = 0;
    rd = 0; lng = 0; fl = 0; wbv = 0; wbrd = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic issue_long(input reg_addr_t d);
    iv = 1; lng = 1; rd = d;
  endtask

  task automatic wb(input reg_addr_t d);
    wbv = 1; wbrd = d;
  endtask

  task automatic state(input string tag,
                       input logic [31:0] p,
                       input logic [3:0] o,
                       input logic e);
    chk({tag, "_pend"}, pend, p);
    chk({tag, "_outs"}, 32'(outs), 32'(o));
    chk({tag, "_busy"}, 32'(busy), 32'(o != 0));
    chk({tag, "_err"}, 32'(err), 32'(e));
  endtask

  initial begin
    clr();
    rst_n = 0;
    #12;
    state("rst", 32'h0, 4'd0, 1'b0);
    rst_n = 1;
    tick();

    // RAW with writeback bypass
    issue_long(5);
    #1 chk("raw_iss", 32'(stall), 32'd0);
    tick();
    state("raw_set", 32'h20, 4'd1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      iv = 1; u1 = 1; rs1 = 5; rd = 10;
      if (c == 2) wb(5);
      #1 chk($sformatf("raw_c%0d", c), 32'(stall),
             (c == 2) ? 32'd0 : 32'd1);
      tick();
    end
    state("raw_done", 32'h0, 4'd0, 1'b0);

    // long issue to x0
    issue_long(0);
    tick();
    state("x0_iss", 32'h0, 4'd1, 1'b0);
    wb(0);
    tick();
    state("x0_wb", 32'h0, 4'd0, 1'b0);

    // capacity
    for (int r = 1; r <= 4; r++) begin
      issue_long(reg_addr_t'(r));
      tick();
    end
    state("cap_full", 32'h1E, 4'd4, 1'b0);
    issue_long(6);
    #1 chk("cap_stall", 32'(stall), 32'd1);
    wb(1);
    #1 chk("cap_bypass", 32'(stall), 32'd0);
    tick();
    state("cap_acc", 32'h5C, 4'd4, 1'b0);
    wb(2); tick();
    wb(3); tick();
    wb(4); tick();
    wb(6); tick();
    state("drain", 32'h0, 4'd0, 1'b0);

    // set wins over clear
    issue_long(7);
    tick();
    state("p7", 32'h80, 4'd1, 1'b0);
    issue_long(7);
    wb(7);
    #1 chk("sw_stall", 32'(stall), 32'd0);
    tick();
    state("sw", 32'h80, 4'd1, 1'b0);

    // WAW on pending 7, rs2 RAW too
    iv = 1; rd = 7;
    #1 chk("waw", 32'(stall), 32'd1);
    rd = 8; u2 = 1; rs2 = 7;
    #1 chk("raw2", 32'(stall), 32'd1);
    u2 = 0;
    #1 chk("nohaz", 32'(stall), 32'd0);
    clr();
    wb(7);
    tick();
    state("p7clr", 32'h0, 4'd0, 1'b0);

    // flush
    issue_long(9);
    fl = 1;
    #1 chk("fl_stall", 32'(stall), 32'd0);
    tick();
    state("fl", 32'h0, 4'd0, 1'b0);

    // unmatched writeback with count nonzero
    issue_long(0);
    tick();
    wb(12);
    tick();
    state("wb_bad", 32'h0, 4'd0, 1'b1);
    rst_n = 0;
    #1;
    state("rst2", 32'h0, 4'd0, 1'b0);
    #2 rst_n = 1;
    tick();

    // underflow, sticky, async reset
    issue_long(3);
    tick();
    wb(3);
    tick();
    state("uf_pre", 32'h0, 4'd0, 1'b0);
    wb(3);
    tick();
    state("uf", 32'h0, 4'd0, 1'b1);
    issue_long(5);
    tick();
    tick();
    state("sticky", 32'h20, 4'd1, 1'b1);
    #2 rst_n = 0;
    #1;
    state("arst", 32'h0, 4'd0, 1'b0);
    iv = 1; u1 = 1; rs1 = 5;
    #1 chk("rst_stall", 32'(stall), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 The block SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of in-flight long-latency ops (range 1..15).
REQ-002 The block SHALL have the following ports:
- clk_i  input  1  clock; all state changes on its rising edge.
- rst_ni  input  1  reset; asynchronous, active-low.
- issue_valid_i  input  1  ID holds an instruction requesting issue to EX this cycle.
- issue_rs1_i  input  5  source register 1 address.
- issue_rs2_i  input  5  source register 2 address.
- issue_uses_rs1_i  input  1  instruction reads rs1.
- issue_uses_rs2_i  input  1  instruction reads rs2.
- issue_rd_i  input  5  destination register address.
- issue_long_i  input  1  instruction is long-latency (load, mul/div).
- flush_i  input  1  the ID-stage instruction is killed this cycle.
- wb_valid_i  input  1  a long-latency op writes back this cycle.
- wb_rd_i  input  5  writeback destination address.
- stall_o  output  1  hold ID; the issue is not accepted.
- pending_o  output  32  per-register pending-write bits.
- outstanding_o  output  4  count of in-flight long-latency ops.
- busy_o  output  1  outstanding_o != 0.
- err_o  output  1  sticky protocol-error flag.

Function
REQ-003 pending_o[0] SHALL be constant 0: x0 is never marked pending and never causes a hazard.
REQ-004 A RAW hazard SHALL exist when (issue_uses_rs1_i and pending[rs1]) or (issue_uses_rs2_i and pending[rs2]), where pending[r] is masked when wb_valid_i and wb_rd_i == r (same-cycle writeback bypass).
REQ-005 A WAW hazard SHALL exist when issue_rd_i != 0 and pending[issue_rd_i], with the same writeback mask as REQ-004.
REQ-006 A capacity hazard SHALL exist when issue_long_i and outstanding_o == MAX_OUTSTANDING and not wb_valid_i.
REQ-007 stall_o SHALL be combinational: issue_valid_i and not flush_i and (RAW or WAW or capacity hazard).
REQ-008 An issue SHALL be accepted when issue_valid_i and not flush_i and not stall_o.
REQ-009 An accepted issue with issue_long_i and issue_rd_i != 0 SHALL set pending[issue_rd_i] at the next edge.
REQ-010 wb_valid_i with wb_rd_i != 0 SHALL clear pending[wb_rd_i] at the next edge.
REQ-011 When the set from REQ-009 and the clear from REQ-010 hit the same register in the same cycle, the set SHALL win.
REQ-012 outstanding SHALL increment on every accepted long issue (including rd = x0) and decrement on every wb_valid_i; when both occur in one cycle it SHALL stay unchanged.
REQ-013 wb_valid_i with outstanding_o == 0 and no same-cycle accepted long issue SHALL leave the count at 0 and set err_o.
REQ-014 wb_valid_i for a register whose pending bit is clear (rd != 0) SHALL set err_o; the count rule in REQ-012 still applies.
REQ-015 err_o SHALL be sticky until reset.
REQ-016 flush_i SHALL suppress only the current-cycle issue; in-flight ops still complete, and their writebacks still clear pending bits and decrement the count.
REQ-017 Latency: pending_o and outstanding_o SHALL reflect an accepted issue or writeback one cycle after it.

Reset
REQ-018 Asserting rst_ni low SHALL immediately clear pending to 0, outstanding to 0 and err_o to 0; stall_o then depends only on inputs.
REQ-019 Reset mid-operation SHALL discard all in-flight tracking; later writebacks SHALL be handled per REQ-013 and REQ-014.

Structure
REQ-020 reg_addr_t (logic [4:0]), NUM_REGS = 32 and the MAX_OUTSTANDING default SHALL live in riscv_pkg.
REQ-021 The block SHALL have no sub-module; it is a single module with a 31-bit pending register, a 4-bit counter and an error flop.

Verification
REQ-022 Issue long rd=5, then issue_uses_rs1_i with rs1=5 for 3 cycles -> stall_o=1 for each; wb rd=5 on cycle 3 -> stall_o=0 that cycle (bypass), pending_o[5]=0 next cycle.
REQ-023 Long issue rd=0, then wb rd=0 -> pending_o stays 0; outstanding_o goes 1 then 0; err_o stays 0.
REQ-024 Four long issues to rd=1..4 (MAX=4), then a fifth long to rd=6 -> stall_o=1; add wb rd=1 that cycle -> issue accepted, outstanding_o stays 4.
REQ-025 pending[7] set; same cycle issue long rd=7 and wb rd=7 -> no stall; pending_o[7]=1 next cycle; outstanding_o unchanged.
REQ-026 wb_valid_i with outstanding_o=0 -> err_o=1 and remains 1; assert rst_ni low -> err_o=0, pending_o=0, outstanding_o=0 asynchronously.
REQ-027 flush_i=1 with a long issue rd=9 -> stall_o=0, pending_o[9]=0, outstanding_o unchanged.
